// File: rtl/gray_pkg.sv
// Shared constants and helpers for the binary/Gray conversion slice.
// gray2bin and popcount serve as independent checking models.
package gray_pkg;

  localparam int GRAY_DEFAULT_WIDTH = 4;

  function automatic logic [31:0] bin2gray(
    input logic [31:0] bin
  );
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down undoes the Gray mapping.
  function automatic logic [31:0] gray2bin(
    input logic [31:0] gray
  );
    logic [31:0] b;
    b[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ gray[i];
    end
    return b;
  endfunction

  function automatic logic [5:0] popcount(
    input logic [31:0] v
  );
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_xor_stage.sv
// Combinational binary-to-reflected-Gray mapping.
// The MSB passes through; each lower bit is XORed with its upper neighbour.
module gray_xor_stage #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_encoder.sv
// Registered binary-to-Gray converter with valid qualifier.
// Also flags whether each new code is one bit away from the last.
module gray_encoder
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] binary_num,
  input  logic             in_valid,
  output logic [WIDTH-1:0] gray_code,
  output logic             out_valid,
  output logic             adjacent
);

  logic [WIDTH-1:0] conv_gray;
  logic [WIDTH-1:0] gray_d, gray_q;
  logic             valid_d, valid_q;
  logic             adj_d, adj_q;
  logic             have_d, have_q;

  gray_xor_stage #(
    .WIDTH (WIDTH)
  ) u_xor (
    .bin_i  (binary_num),
    .gray_o (conv_gray)
  );

  // gray_q holds across idle cycles, so it doubles as history.
  always_comb begin
    gray_d  = gray_q;
    valid_d = 1'b0;
    adj_d   = 1'b0;
    have_d  = have_q;
    if (in_valid) begin
      gray_d  = conv_gray;
      valid_d = 1'b1;
      adj_d   = have_q && $onehot(conv_gray ^ gray_q);
      have_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q  <= '0;
      valid_q <= 1'b0;
      adj_q   <= 1'b0;
      have_q  <= 1'b0;
    end else begin
      gray_q  <= gray_d;
      valid_q <= valid_d;
      adj_q   <= adj_d;
      have_q  <= have_d;
    end
  end

  assign gray_code = gray_q;
  assign out_valid = valid_q;
  assign adjacent  = adj_q;

endmodule

// File: tb/tb_gray_encoder.sv
// Self-checking bench: directed WIDTH=4 sequences plus random WIDTH=8.
// Expectations come from a bit-rule model with Hamming-distance history.
module tb_gray_encoder;
  import gray_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] bin4;
  logic       vin4;
  logic [3:0] gray4;
  logic       vout4;
  logic       adj4;
  logic [7:0] bin8;
  logic       vin8;
  logic [7:0] gray8;
  logic       vout8;
  logic       adj8;

  int n_chk;
  int n_err;

  // model state, WIDTH=4
  logic [3:0] m_prev4;
  logic       m_have4;
  logic [3:0] e_gray4;
  logic       e_v4;
  logic       e_adj4;
  // model state, WIDTH=8
  logic [7:0] m_prev8;
  logic       m_have8;
  logic [7:0] e_gray8;
  logic       e_v8;
  logic       e_adj8;
  logic [7:0] last_bin8;

  gray_encoder u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .binary_num (bin4),
    .in_valid   (vin4),
    .gray_code  (gray4),
    .out_valid  (vout4),
    .adjacent   (adj4)
  );

  gray_encoder #(
    .WIDTH (8)
  ) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .binary_num (bin8),
    .in_valid   (vin8),
    .gray_code  (gray8),
    .out_valid  (vout8),
    .adjacent   (adj8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Gray code straight from the per-bit rule.
  function automatic logic [31:0] ref_gray(
    input logic [31:0] b,
    input int          w
  );
    logic [31:0] g;
    g = '0;
    for (int i = 0; i < w; i++) begin
      if (i == w - 1) g[i] = b[i];
      else            g[i] = b[i+1] ^ b[i];
    end
    return g;
  endfunction

  function automatic int hdist(
    input logic [31:0] a,
    input logic [31:0] b
  );
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (a[i] != b[i]) n++;
    end
    return n;
  endfunction

  // One clock: drive both DUTs, advance the model, check all outputs.
  task automatic step(
    input logic       r,
    input logic [3:0] b4,
    input logic       v4
  );
    logic [7:0] b8;
    logic       v8;
    b8 = 8'($urandom);
    v8 = ($urandom_range(3) != 0);
    @(negedge clk);
    rst  = r;
    bin4 = b4;
    vin4 = v4;
    bin8 = b8;
    vin8 = v8;
    @(posedge clk);
    if (r) begin
      m_prev4 = '0; m_have4 = 1'b0;
      e_gray4 = '0; e_v4 = 1'b0; e_adj4 = 1'b0;
      m_prev8 = '0; m_have8 = 1'b0;
      e_gray8 = '0; e_v8 = 1'b0; e_adj8 = 1'b0;
    end else begin
      if (v4) begin
        e_gray4 = 4'(ref_gray({28'd0, b4}, 4));
        e_adj4  = m_have4 && (hdist({28'd0, e_gray4}, {28'd0, m_prev4}) == 1);
        e_v4    = 1'b1;
        m_prev4 = e_gray4;
        m_have4 = 1'b1;
      end else begin
        e_v4   = 1'b0;
        e_adj4 = 1'b0;
      end
      if (v8) begin
        e_gray8   = 8'(ref_gray({24'd0, b8}, 8));
        e_adj8    = m_have8 && (hdist({24'd0, e_gray8}, {24'd0, m_prev8}) == 1);
        e_v8      = 1'b1;
        m_prev8   = e_gray8;
        m_have8   = 1'b1;
        last_bin8 = b8;
      end else begin
        e_v8   = 1'b0;
        e_adj8 = 1'b0;
      end
    end
    #1;
    chk("gray4",  {28'd0, gray4}, {28'd0, e_gray4});
    chk("valid4", {31'd0, vout4}, {31'd0, e_v4});
    chk("adj4",   {31'd0, adj4},  {31'd0, e_adj4});
    chk("gray8",  {24'd0, gray8}, {24'd0, e_gray8});
    chk("valid8", {31'd0, vout8}, {31'd0, e_v8});
    chk("adj8",   {31'd0, adj8},  {31'd0, e_adj8});
    if (e_v8) begin
      chk("rt8", gray2bin({24'd0, gray8}), {24'd0, last_bin8});
    end
  endtask

  logic [3:0] sweep_tab [16];

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    bin4  = '0;
    vin4  = 1'b0;
    bin8  = '0;
    vin8  = 1'b0;
    m_prev4 = '0; m_have4 = 1'b0;
    e_gray4 = '0; e_v4 = 1'b0; e_adj4 = 1'b0;
    m_prev8 = '0; m_have8 = 1'b0;
    e_gray8 = '0; e_v8 = 1'b0; e_adj8 = 1'b0;
    last_bin8 = '0;
    sweep_tab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    step(1'b1, 4'h0, 1'b0);
    step(1'b1, 4'h0, 1'b0);

    // full sweep with constant-table cross-check
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 4'(i), 1'b1);
      chk("sweep_tab", {28'd0, gray4}, {28'd0, sweep_tab[i]});
      chk("sweep_adj", {31'd0, adj4}, (i == 0) ? 32'd0 : 32'd1);
    end

    // spot values and a non-adjacent jump
    step(1'b0, 4'b0111, 1'b1);
    chk("spot_0111", {28'd0, gray4}, 32'b0100);
    step(1'b0, 4'b1000, 1'b1);
    chk("spot_1000", {28'd0, gray4}, 32'b1100);
    step(1'b0, 4'b0011, 1'b1);
    chk("spot_0011", {28'd0, gray4}, 32'b0010);
    step(1'b0, 4'b1010, 1'b1);
    chk("spot_1010", {28'd0, gray4}, 32'b1111);
    chk("jump_adj", {31'd0, adj4}, 32'd0);

    // wrap-around, then repeat
    step(1'b0, 4'b1111, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    chk("wrap_adj", {31'd0, adj4}, 32'd1);
    step(1'b0, 4'b0000, 1'b1);
    chk("repeat_adj", {31'd0, adj4}, 32'd0);

    // idle gap keeps history
    step(1'b0, 4'b0101, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'($urandom), 1'b0);
      chk("gap_hold", {28'd0, gray4}, 32'b0111);
    end
    step(1'b0, 4'b0110, 1'b1);
    chk("gap_gray", {28'd0, gray4}, 32'b0101);
    chk("gap_adj", {31'd0, adj4}, 32'd1);

    // reset mid-stream drops the sample and history
    step(1'b1, 4'b1001, 1'b1);
    chk("rst_gray", {28'd0, gray4}, 32'd0);
    step(1'b0, 4'b0001, 1'b1);
    chk("post_rst_adj", {31'd0, adj4}, 32'd0);

    // random traffic on both widths
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(99) == 0), 4'($urandom), ($urandom_range(3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gray_encoder.md
Name: gray_encoder

Overview:
Registered binary-to-reflected-Gray-code converter with a valid qualifier and an adjacency monitor. Each accepted binary word produces its Gray equivalent one clock later. A flag reports whether the new code differs from the previous valid code in exactly one bit. It sits at the boundary between binary counters and consumers that need single-bit-change codes, such as pointer synchronisers and position encoders.

Parameters:
WIDTH, 4, bit width of the binary input and the Gray output; legal range 1..32.

Ports:
clk  input  1  rising-edge clock, the only clock.
rst  input  1  synchronous, active-high reset.
binary_num  input  WIDTH  binary value to encode.
in_valid  input  1  binary_num is valid this cycle.
gray_code  output  WIDTH  registered Gray code of the last accepted binary_num.
out_valid  output  1  gray_code was updated on the preceding edge.
adjacent  output  1  current gray_code differs from the previous valid gray_code in exactly one bit.

Behaviour:
- Conversion rule, per bit:
  - gray[WIDTH-1] = bin[WIDTH-1].
  - gray[i] = bin[i+1] XOR bin[i], for i = WIDTH-2 down to 0.
  - Pure bitwise; no arithmetic; no width growth.
- Reset: on a rising clk edge with rst=1:
  - gray_code, out_valid and adjacent all go to 0.
  - The internal history register goes to 0 and its have_prev flag is cleared.
  - rst has priority over in_valid.
- Latency: exactly 1 cycle.
  - A sample accepted at edge N (in_valid=1, rst=0) appears on gray_code with out_valid=1 after edge N.
  - Throughput is one word per cycle with no back-pressure.
- When in_valid=0 at an edge:
  - gray_code holds its value.
  - out_valid goes to 0.
  - adjacent goes to 0.
- History: the previous valid gray_code is retained across idle cycles. Idle cycles do not break adjacency tracking.
- adjacent at an accepted edge:
  - 1 iff have_prev=1 and popcount(new_gray XOR prev_gray) == 1.
  - Otherwise 0.
  - have_prev is then set.
- First sample after reset: adjacent=0, because no history exists.
- Repeated identical input: XOR is 0 and popcount is 0, so adjacent=0.
- Wrap-around: the full-scale code (binary all-ones) followed by 0 is a single-bit change, so adjacent=1.
- Reset mid-stream: the sample presented in the reset cycle is discarded, and history restarts from empty.
- WIDTH=1: gray equals bin.
- All outputs are driven only from flops; there is no combinational path from inputs to outputs.

Decomposition:
- Package gray_pkg:
  - Constant GRAY_DEFAULT_WIDTH = 4.
  - Function bin2gray (bin XOR (bin >> 1)).
  - Function gray2bin (prefix XOR), used by benches as the checking model.
  - Function popcount.
- One combinational sub-module, gray_xor_stage, performing the bin2gray mapping. It is instantiated once; all registers stay in gray_encoder.

Test Plan:
1. Reset then sweep binary_num 0..15 (WIDTH=4), in_valid=1 every cycle.
   - Gray outputs, one cycle later: 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000.
   - out_valid=1 throughout.
   - adjacent=0 on the first output, then 1 on every later output.
2. Spot values:
   - 0011 -> 0010.
   - 0111 -> 0100.
   - 1000 -> 1100.
   - 1010 -> 1111.
   - Non-sequential order 0011 then 1010 -> adjacent=0 on the second output (0010 vs 1111).
3. Wrap: 1111 then 0000 -> gray 1000 then 0000, adjacent=1. Repeat 0000 -> adjacent=0.
4. Idle gaps: 0101, then in_valid=0 for 3 cycles, then 0110.
   - gray_code holds 0111 during the gap, with out_valid=0 and adjacent=0.
   - The next output is 0101 with adjacent=1.
5. Reset mid-stream: assert rst while in_valid=1 and binary_num=1001.
   - Next cycle: gray_code=0000, out_valid=0, adjacent=0.
   - The first sample after reset (0001) gives gray 0001 with adjacent=0.
6. WIDTH=8, random 1000 samples: gray_code equals bin2gray(input) with 1-cycle latency, and gray2bin(gray_code) recovers the input.
